// File: rtl/mpc_mac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mpc_mac_pkg
// Purpose  : shared widths, legal parameter ranges and saturation helper
// Revision : 1.0
// ============================================================================
package mpc_mac_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 6;
  localparam int SHIFT_MIN  = 0;
  // Widest value the saturation helper accepts; every caller stays below it.
  localparam int SAT_MAX_W  = 128;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    logic                        flag;
  } sat_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 2;
  endfunction

  function automatic sat_t sat_signed(input logic signed [SAT_MAX_W-1:0] value,
                                      input int                          width);
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    sat_t                        res;
    one   = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    max_v = (one <<< (width - 1)) - one;
    min_v = -(one <<< (width - 1));
    if (value > max_v) begin
      res.value = max_v;
      res.flag  = 1'b1;
    end else if (value < min_v) begin
      res.value = min_v;
      res.flag  = 1'b1;
    end else begin
      res.value = value;
      res.flag  = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpc_mac_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : mpc_mac_round_sat
// Purpose  : round-half-up arithmetic right shift, then saturate to P_W
// Revision : 1.0
// ============================================================================
module mpc_mac_round_sat import mpc_mac_pkg::*; #(
  parameter int ACC_W = 40,
  parameter int SHIFT = 0,
  parameter int P_W   = 28
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [P_W-1:0]   p_next,
  output logic                    out_sat
);

  // One extra bit so adding the rounding constant to +max cannot wrap.
  localparam logic [ACC_W:0]        c_one   = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] c_round = $signed((c_one << SHIFT) >> 1);

  logic signed [ACC_W:0] w_biased;
  logic signed [ACC_W:0] w_shifted;
  sat_t                  w_res;
  logic                  w_unused;

  assign w_biased  = (ACC_W+1)'(sum) + c_round;
  assign w_shifted = w_biased >>> SHIFT;
  assign w_res     = sat_signed(SAT_MAX_W'(w_shifted), P_W);
  assign p_next    = w_res.value[P_W-1:0];
  assign out_sat   = w_res.flag;
  assign w_unused  = ^w_res.value[SAT_MAX_W-1:P_W];

endmodule
`default_nettype wire

// File: rtl/mpc_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mpc_mac_pipe
// Purpose  : pipelined multiply-accumulate with clock enable, valid tracking,
//            saturating accumulator, rounding shift and saturating output
// Revision : 1.0
// ============================================================================
module mpc_mac_pipe import mpc_mac_pkg::*; #(
  parameter int A_W      = 21,
  parameter int B_W      = 6,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 0,
  parameter int STAGES   = 3,
  parameter int ACC_W    = 40,
  parameter int SHIFT    = 0,
  parameter int P_W      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [A_W-1:0]        a,
  input  logic [B_W-1:0]        b,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic signed [P_W-1:0] p,
  output logic                  ovf
);

  localparam int PW = prod_width(A_W, B_W);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mpc_mac_pipe: STAGES out of range");
  end
  if (SHIFT < SHIFT_MIN || SHIFT > ACC_W - 2) begin : g_bad_shift
    $error("mpc_mac_pipe: SHIFT out of range");
  end
  if (ACC_W < A_W + B_W + 1 || ACC_W + 1 >= SAT_MAX_W) begin : g_bad_acc_w
    $error("mpc_mac_pipe: ACC_W out of range");
  end

  // Index 0 of the sideband vectors is stage 1; index STAGES-1 is the last stage.
  logic signed [A_W:0]       a_q, a_d;
  logic signed [B_W:0]       b_q, b_d;
  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0]         en_q, en_d;
  logic [STAGES-1:0]         clr_q, clr_d;
  logic signed [PW-1:0]      prod_q [STAGES-1];
  logic signed [PW-1:0]      prod_d [STAGES-1];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [P_W-1:0]     p_q, p_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [A_W:0]       w_a_ext;
  logic signed [B_W:0]       w_b_ext;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_prod_last;
  logic signed [ACC_W:0]     w_acc_sum;
  sat_t                      w_acc_res;
  logic                      w_restart;
  logic                      w_acc_sat;
  logic signed [ACC_W-1:0]   w_new_sum;
  logic signed [P_W-1:0]     w_p_next;
  logic                      w_out_sat;
  logic                      w_unused;

  assign w_a_ext     = (A_SIGNED != 0) ? {a[A_W-1], a} : {1'b0, a};
  assign w_b_ext     = (B_SIGNED != 0) ? {b[B_W-1], b} : {1'b0, b};
  assign w_prod      = PW'(a_q) * PW'(b_q);
  assign w_prod_last = prod_q[STAGES-2];

  // The product always fits in ACC_W, so a restart can never saturate.
  assign w_restart = clr_q[STAGES-1] | ~en_q[STAGES-1];
  assign w_acc_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(w_prod_last);
  assign w_acc_res = sat_signed(SAT_MAX_W'(w_acc_sum), ACC_W);
  assign w_acc_sat = ~w_restart & w_acc_res.flag;
  assign w_new_sum = w_restart ? ACC_W'(w_prod_last) : w_acc_res.value[ACC_W-1:0];
  assign w_unused  = ^w_acc_res.value[SAT_MAX_W-1:ACC_W];

  mpc_mac_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .P_W   (P_W)
  ) u_round_sat (
    .sum     (w_new_sum),
    .p_next  (w_p_next),
    .out_sat (w_out_sat)
  );

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    vld_d       = vld_q;
    en_d        = en_q;
    clr_d       = clr_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (ce) begin
      a_d       = w_a_ext;
      b_d       = w_b_ext;
      vld_d     = {vld_q[STAGES-2:0], in_valid};
      en_d      = {en_q[STAGES-2:0], acc_en};
      clr_d     = {clr_q[STAGES-2:0], acc_clr};
      prod_d[0] = w_prod;
      for (int i = 1; i < STAGES - 1; i++) begin
        prod_d[i] = prod_q[i-1];
      end
      out_valid_d = vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        acc_d = w_new_sum;
        p_d   = w_p_next;
        ovf_d = w_acc_sat | w_out_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      vld_q       <= '0;
      en_q        <= '0;
      clr_q       <= '0;
      for (int i = 0; i < STAGES - 1; i++) begin
        prod_q[i] <= '0;
      end
      acc_q       <= '0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      vld_q       <= vld_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mpc_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpc_mac_pipe
// Purpose  : directed + random check of four mpc_mac_pipe variants against
//            an arithmetic reference model
// Revision : 1.0
// ============================================================================
module tb_mpc_mac_pipe;

  localparam int NDUT   = 4;
  localparam int STAGES = 3;
  // Variants: default, narrow output, rounding shift, narrow accumulator.
  localparam int C_PW   [NDUT] = '{28, 16, 28, 28};
  localparam int C_SH   [NDUT] = '{0, 0, 4, 0};
  localparam int C_ACCW [NDUT] = '{40, 40, 40, 28};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic [20:0] a = '0;
  logic [5:0]  b = '0;
  logic        acc_en = 1'b0;
  logic        acc_clr = 1'b0;

  logic        ov0, ov1, ov2, ov3;
  logic        of0, of1, of2, of3;
  logic [27:0] p0;
  logic [15:0] p1;
  logic [27:0] p2;
  logic [27:0] p3;

  always #5 clk = ~clk;

  mpc_mac_pipe #(.P_W(C_PW[0]), .SHIFT(C_SH[0]), .ACC_W(C_ACCW[0])) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov0), .p(p0), .ovf(of0));
  mpc_mac_pipe #(.P_W(C_PW[1]), .SHIFT(C_SH[1]), .ACC_W(C_ACCW[1])) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov1), .p(p1), .ovf(of1));
  mpc_mac_pipe #(.P_W(C_PW[2]), .SHIFT(C_SH[2]), .ACC_W(C_ACCW[2])) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov2), .p(p2), .ovf(of2));
  mpc_mac_pipe #(.P_W(C_PW[3]), .SHIFT(C_SH[3]), .ACC_W(C_ACCW[3])) dut3 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov3), .p(p3), .ovf(of3));

  int     n_checks = 0;
  int     n_fail   = 0;
  int     pulse_cnt = 0;

  // Reference state: running sum per variant plus results awaiting latency.
  longint acc_m   [NDUT];
  longint exp_p   [NDUT];
  bit     exp_ovf [NDUT];
  bit     exp_vld;
  bit     pend_vld [$];
  longint pend_p   [$];
  bit     pend_ovf [$];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w, output bit hit);
    longint lim;
    lim = 64'sd1 <<< (w - 1);
    hit = 1'b0;
    if (v > lim - 1) begin
      hit = 1'b1;
      return lim - 1;
    end
    if (v < -lim) begin
      hit = 1'b1;
      return -lim;
    end
    return v;
  endfunction

  task automatic model_sample(input int d, input logic [20:0] ar, input logic [5:0] br,
                              input bit en, input bit clr,
                              output longint p_o, output bit ovf_o);
    longint prod, sum, r;
    bit     aov, pov;
    prod = longint'($signed(ar)) * longint'(br);
    aov  = 1'b0;
    if (clr || !en) sum = prod;
    else            sum = clamp(acc_m[d] + prod, C_ACCW[d], aov);
    acc_m[d] = sum;
    r = sum;
    if (C_SH[d] > 0) r = r + (64'sd1 <<< (C_SH[d] - 1));
    r     = r >>> C_SH[d];
    p_o   = clamp(r, C_PW[d], pov);
    ovf_o = aov | pov;
  endtask

  task automatic model_clear();
    pend_vld.delete();
    pend_p.delete();
    pend_ovf.delete();
    exp_vld = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      acc_m[d]   = 0;
      exp_p[d]   = 0;
      exp_ovf[d] = 1'b0;
    end
  endtask

  // Called once per enabled clock edge; a result emerges STAGES edges after capture.
  task automatic model_edge();
    longint pv;
    bit     fv;
    pend_vld.push_back(in_valid);
    for (int d = 0; d < NDUT; d++) begin
      pv = 0;
      fv = 1'b0;
      if (in_valid) model_sample(d, a, b, acc_en, acc_clr, pv, fv);
      pend_p.push_back(pv);
      pend_ovf.push_back(fv);
    end
    exp_vld = 1'b0;
    if (pend_vld.size() > STAGES) begin
      exp_vld = pend_vld.pop_front();
      for (int d = 0; d < NDUT; d++) begin
        pv = pend_p.pop_front();
        fv = pend_ovf.pop_front();
        if (exp_vld) begin
          exp_p[d]   = pv;
          exp_ovf[d] = fv;
        end
      end
    end
  endtask

  task automatic compare_all();
    longint po [NDUT];
    bit     vo [NDUT];
    bit     fo [NDUT];
    po[0] = longint'($signed(p0)); vo[0] = ov0; fo[0] = of0;
    po[1] = longint'($signed(p1)); vo[1] = ov1; fo[1] = of1;
    po[2] = longint'($signed(p2)); vo[2] = ov2; fo[2] = of2;
    po[3] = longint'($signed(p3)); vo[3] = ov3; fo[3] = of3;
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("d%0d_out_valid", d), longint'(vo[d]), longint'(exp_vld));
      check_eq($sformatf("d%0d_p", d), po[d], exp_p[d]);
      check_eq($sformatf("d%0d_ovf", d), longint'(fo[d]), longint'(exp_ovf[d]));
    end
  endtask

  initial begin : monitor
    bit edge_ce, edge_rst;
    forever begin
      @(posedge clk);
      edge_ce  = ce;
      edge_rst = rst;
      if (edge_rst && edge_ce) model_edge();
      #1;
      if (edge_rst && edge_ce && ov0) pulse_cnt++;
      compare_all();
    end
  end

  task automatic drive(input bit v, input longint av, input longint bv,
                       input bit en, input bit clr, input bit c);
    @(negedge clk);
    ce       = c;
    in_valid = v;
    a        = 21'(av);
    b        = 6'(bv);
    acc_en   = en;
    acc_clr  = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check_eq("rst_out_valid", longint'(ov0 | ov1 | ov2 | ov3), 0);
    check_eq("rst_p0", longint'($signed(p0)), 0);
    check_eq("rst_p3", longint'($signed(p3)), 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : stimulus
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    drive(1'b1, -1048576, 63, 1'b0, 1'b1, 1'b1);
    idle(6);

    drive(1'b1, 1000, 10, 1'b0, 1'b1, 1'b1);
    drive(1'b1, -200, 5, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 7, 63, 1'b1, 1'b0, 1'b1);
    idle(6);

    drive(1'b1, 1000, 63, 1'b0, 1'b1, 1'b1);
    drive(1'b1, -1000, 63, 1'b0, 1'b1, 1'b1);
    idle(6);

    drive(1'b1, -24, 1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 24, 1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 23, 1, 1'b0, 1'b1, 1'b1);
    idle(6);

    // Drives the 28-bit accumulator into its clamp and back out again.
    drive(1'b1, 1048575, 63, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1048575, 63, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1048575, 63, 1'b1, 1'b0, 1'b1);
    drive(1'b1, -1, 1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 5, 3, 1'b1, 1'b0, 1'b1);
    idle(6);

    pulse_cnt = 0;
    drive(1'b1, 11, 2, 1'b0, 1'b1, 1'b1);
    drive(1'b1, -7, 9, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 300, 40, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 99999, 33, 1'b0, 1'b1, 1'b0);
    drive(1'b1, -5000, 17, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 42, 42, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1, 63, 1'b1, 1'b0, 1'b1);
    idle(8);
    check_eq("stall_pulse_count", pulse_cnt, 6);

    drive(1'b1, 12345, 50, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 54321, 20, 1'b1, 1'b0, 1'b1);
    drive(1'b1, -777, 61, 1'b1, 1'b0, 1'b1);
    async_reset();
    drive(1'b1, 300, 7, 1'b1, 1'b0, 1'b1);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      drive(($urandom % 4) != 0, longint'($urandom_range(0, 2097151)),
            longint'($urandom_range(0, 63)), ($urandom % 4) != 0,
            ($urandom % 6) == 0, ($urandom % 5) != 0);
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
